// File: rtl/writeback_pkg.sv
// Shared constants and the registered write-port record for the writeback arbiter.
// The scoreboard in writeback_arbiter is built only when WRITEBACK_SCOREBOARD_EN is defined.
package writeback_pkg;

  localparam int WB_DATA_WIDTH = 32;
  localparam int WB_ADDR_WIDTH = 5;
  localparam int WB_NUM_REGS   = 32;
  localparam int WB_REQUESTERS = 3;
  // Wide enough to name any of the up-to-8 requesters.
  localparam int WB_SRC_WIDTH  = 3;

  typedef struct packed {
    logic                     enable;
    logic [WB_ADDR_WIDTH-1:0] address;
    logic [WB_DATA_WIDTH-1:0] data;
    logic [WB_SRC_WIDTH-1:0]  source;
  } wb_write_t;

endpackage

// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer and
// moves the pointer past the winner whenever the grant is used.
module round_robin_arbiter #(
  parameter  int N     = 3,
  localparam int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     i_request,
  input  logic             i_advance,
  output logic [N-1:0]     o_grant,
  output logic [IDX_W-1:0] o_index
);

  logic [IDX_W-1:0] r_ptr;
  logic [N-1:0]     w_grant;
  logic [IDX_W-1:0] w_index;
  logic             w_found;
  // One spare bit so ptr + offset never wraps before the modulo correction.
  logic [IDX_W:0]   w_pos;

  always_comb begin
    w_grant = '0;
    w_index = '0;
    w_found = 1'b0;
    w_pos   = '0;
    for (int k = 0; k < N; k++) begin
      w_pos = {1'b0, r_ptr} + (IDX_W+1)'(k);
      if (w_pos >= (IDX_W+1)'(N)) w_pos = w_pos - (IDX_W+1)'(N);
      if (!w_found && i_request[w_pos[IDX_W-1:0]]) begin
        w_found                   = 1'b1;
        w_grant[w_pos[IDX_W-1:0]] = 1'b1;
        w_index                   = w_pos[IDX_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_advance) begin
      r_ptr <= (w_index == IDX_W'(N-1)) ? '0 : w_index + 1'b1;
    end
  end

  assign o_grant = rst ? '0 : w_grant;
  assign o_index = w_index;

endmodule

// File: rtl/writeback_arbiter.sv
// Shares the register-file write port among REQUESTERS sources; optional pending-write
// scoreboard enabled by defining WRITEBACK_SCOREBOARD_EN (otherwise busy outputs read 0).
module writeback_arbiter
  import writeback_pkg::*;
#(
  parameter  int REQUESTERS = WB_REQUESTERS,
  parameter  int DATA_WIDTH = WB_DATA_WIDTH,
  parameter  int ADDR_WIDTH = WB_ADDR_WIDTH,
  localparam int IDX_W      = $clog2(REQUESTERS)
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [REQUESTERS-1:0]            requestValid,
  output logic [REQUESTERS-1:0]            requestReady,
  input  logic [REQUESTERS*ADDR_WIDTH-1:0] requestAddress,
  input  logic [REQUESTERS*DATA_WIDTH-1:0] requestData,
  output logic                             writeEnabled,
  output logic [ADDR_WIDTH-1:0]            writeAddress,
  output logic [DATA_WIDTH-1:0]            writeData,
  output logic [IDX_W-1:0]                 grantIndex,
  input  logic                             reserveValid,
  input  logic [ADDR_WIDTH-1:0]            reserveAddress,
  input  logic [ADDR_WIDTH-1:0]            queryAddressA,
  input  logic [ADDR_WIDTH-1:0]            queryAddressB,
  output logic                             busyA,
  output logic                             busyB,
  output logic [WB_NUM_REGS-1:0]           busyBits,
  output logic                             reserveConflict
);

  // Handshake: a transfer happens on a rising edge where requestValid[i] && requestReady[i];
  // ready is a one-hot grant that never depends on downstream state, so the port never stalls.
  logic [IDX_W-1:0]      w_index;
  logic                  w_transfer;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_data;
  wb_write_t             r_write;

  round_robin_arbiter #(.N(REQUESTERS)) u_rr (
    .clk       (clock),
    .rst       (reset),
    .i_request (requestValid),
    .i_advance (w_transfer),
    .o_grant   (requestReady),
    .o_index   (w_index)
  );

  assign w_transfer = |(requestValid & requestReady);
  assign w_sel_addr = requestAddress[w_index*ADDR_WIDTH +: ADDR_WIDTH];
  assign w_sel_data = requestData[w_index*DATA_WIDTH +: DATA_WIDTH];

  // Writes to x0 are consumed but never reach the register file.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_write <= '0;
    end else if (w_transfer) begin
      r_write.enable  <= (w_sel_addr != '0);
      r_write.address <= w_sel_addr;
      r_write.data    <= w_sel_data;
      r_write.source  <= WB_SRC_WIDTH'(w_index);
    end else begin
      r_write.enable <= 1'b0;
    end
  end

  assign writeEnabled = r_write.enable;
  assign writeAddress = r_write.address;
  assign writeData    = r_write.data;
  assign grantIndex   = r_write.source[IDX_W-1:0];

`ifdef WRITEBACK_SCOREBOARD_EN
  logic [WB_NUM_REGS-1:0] r_busy;
  logic                   r_conflict;
  logic [WB_NUM_REGS-1:0] w_busy_next;
  logic                   w_reserve;
  logic                   w_clear_same;

  assign w_reserve    = reserveValid && (reserveAddress != '0);
  // A register freed on this edge may legitimately be reserved again by a new producer.
  assign w_clear_same = r_write.enable && (r_write.address == reserveAddress);

  always_comb begin
    w_busy_next = r_busy;
    if (r_write.enable) w_busy_next[r_write.address] = 1'b0;
    if (w_reserve)      w_busy_next[reserveAddress]  = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_busy     <= '0;
      r_conflict <= 1'b0;
    end else begin
      r_busy     <= w_busy_next;
      r_conflict <= w_reserve && r_busy[reserveAddress] && !w_clear_same;
    end
  end

  assign busyA           = r_busy[queryAddressA];
  assign busyB           = r_busy[queryAddressB];
  assign busyBits        = r_busy;
  assign reserveConflict = r_conflict;

  logic [WB_SRC_WIDTH-1:0] w_unused;
  assign w_unused = r_write.source;
`else
  logic [WB_SRC_WIDTH+3*ADDR_WIDTH:0] w_unused;
  assign w_unused = {r_write.source, reserveValid, reserveAddress, queryAddressA, queryAddressB};

  assign busyA           = 1'b0;
  assign busyB           = 1'b0;
  assign busyBits        = '0;
  assign reserveConflict = 1'b0;
`endif

endmodule

// File: doc/writeback_arbiter.md
# writeback_arbiter

Shares the register file's single write port among several writeback requesters (ALU, load unit, multiply/divide) using round-robin arbitration and a valid/ready handshake, then drives the register file's write port from a registered stage. An optional scoreboard tracks per-register pending writes so issue logic can stall on read-after-write hazards. Sits between the execute/memory units and the 32×32 register file (x0 hardwired zero).

## Interface
- REQUESTERS, 3: number of writeback sources (2..8)
- DATA_WIDTH, 32: write data width
- ADDR_WIDTH, 5: register address width (32 registers)

- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- requestValid  in  REQUESTERS  requester i has a write pending
- requestReady  out  REQUESTERS  one-hot grant; transfer when valid && ready
- requestAddress  in  REQUESTERS*ADDR_WIDTH  requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- requestData  in  REQUESTERS*DATA_WIDTH  requester i at [i*DATA_WIDTH +: DATA_WIDTH]
- writeEnabled  out  1  to register file
- writeAddress  out  ADDR_WIDTH  to register file
- writeData  out  DATA_WIDTH  to register file
- grantIndex  out  $clog2(REQUESTERS)  source of the write currently on the port
- reserveValid  in  1  issue stage reserves a destination register
- reserveAddress  in  ADDR_WIDTH  register being reserved
- queryAddressA, queryAddressB  in  ADDR_WIDTH  operand addresses to check
- busyA, busyB  out  1  queried register has a pending write
- busyBits  out  32  pending-write bitmap, bit 0 always 0
- reserveConflict  out  1  one-cycle pulse: reserve hit an already-busy register

## Operation
- Arbitration: round-robin pointer P (reset 0). Winner = first i with requestValid[i], searching P, P+1, … mod REQUESTERS. requestReady is combinational, one-hot on winner, all-zero when no valid.
- After a transfer from winner w, P <= (w+1) mod REQUESTERS; P unchanged if no transfer.
- One transfer per cycle; the port never stalls (requestReady does not depend on anything downstream).
- Transfer from w registers writeAddress/writeData/grantIndex; writeEnabled <= 1, except writeEnabled <= 0 when address is 0 (request still consumed).
- No transfer: writeEnabled <= 0; writeAddress/writeData/grantIndex hold.
- Scoreboard: reserveValid sets busyBits[reserveAddress] (ignored for address 0). A registered write (writeEnabled && writeAddress == r) clears bit r at the edge the register file captures it.
- Same-edge reserve and clear of the same register: set wins (new producer in flight).
- Reserve of an already-busy register: bit stays 1, reserveConflict pulses next cycle; issue logic must not do this.
- busyA/busyB = busyBits[query], combinational; query of 0 returns 0.
- Reset: requestReady 0, writeEnabled 0, writeAddress 0, writeData 0, grantIndex 0, busyBits 0, reserveConflict 0, P 0. Reset mid-operation discards the in-flight registered write.

## Timing
- Handshake in cycle k -> writeEnabled/address/data valid in cycle k+1 -> register file updated at end of k+1 -> readable and busy bit low from cycle k+2.
- Latency request-to-port: 1 cycle; throughput 1 write/cycle.
- Reserve in cycle k -> busy visible in cycle k+1.
- Requester waiting with valid held high is granted within REQUESTERS cycles.

## Configuration
- WRITEBACK_SCOREBOARD_EN defined: scoreboard as above.
- Not defined: scoreboard logic removed; ports remain; busyA, busyB, busyBits, reserveConflict tied to 0; reserve inputs ignored. Arbitration and write port unchanged.

## Structure
- Package writeback_pkg: DATA_WIDTH/ADDR_WIDTH/register-count constants, default REQUESTERS, typedef for the registered write (enable, address, data, source).
- One sub-module: round_robin_arbiter (parameter N; inputs request vector, pointer-update strobe; outputs one-hot grant and encoded index; owns P).

## Test plan
- Reset held 2 cycles with all valids high -> requestReady 0, writeEnabled 0, busyBits 0; first cycle after release requester 0 granted.
- Requesters 0,1,2 held valid with addresses 5,6,7, data 0xA0/0xB1/0xC2 -> grants 0,1,2,0 on consecutive cycles; writeAddress 5,6,7,5 one cycle later.
- Single request to address 0, data 0xFFFFFFFF -> requestReady pulses, writeEnabled stays 0, P advances.
- Reserve x9 in cycle 0 -> busyA(query 9)=1 in cycle 1; requester 2 writes x9 in cycle 3 -> writeEnabled cycle 4, busy 0 from cycle 5.
- Reserve x9 same edge as registered write to x9 clears -> busyBits[9] remains 1; second reserve of busy x9 -> reserveConflict pulse.
- Build without WRITEBACK_SCOREBOARD_EN, repeat reserve test -> busy outputs 0 throughout, write-port results identical.
